dmcache_refill_ctrl: RTL and testbench

//  Request front-end and miss handler for the direct-mapped cache (dmcache).

---
 rtl/dmcache_defs_pkg.sv | 20 ++
 rtl/dmcache_refill_ctrl.sv | 138 +++++++++++++
 tb/tb_dmcache_refill_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmcache_defs_pkg.sv
// Shared dmcache geometry and refill FSM state encodings; dmcache and its
// refill controller both import this package so the two sides agree on layout.
package dmcache_defs_pkg;

    localparam int DC_AW         = 8;
    localparam int DC_DW         = 8;
    localparam int DC_INDEX_W    = 2;
    localparam int DC_OFFSET_W   = 2;
    localparam int DC_TAG_W      = DC_AW - DC_INDEX_W - DC_OFFSET_W;
    localparam int DC_LINE_WORDS = 1 << DC_OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MREQ   = 3'd2,
        ST_FILL   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/dmcache_refill_ctrl.sv
// Request front-end and miss handler for dmcache: looks up each read, returns
// hits directly, and on a miss refills the whole line before returning the word.
module dmcache_refill_ctrl
    import dmcache_defs_pkg::*;
#(
    parameter int AW       = DC_AW,
    parameter int DW       = DC_DW,
    parameter int INDEX_W  = DC_INDEX_W,
    parameter int OFFSET_W = DC_OFFSET_W
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            req_valid_i,
    input  logic [AW-1:0]                   req_addr_i,
    output logic                            req_ready_o,
    output logic [AW-1:0]                   lookup_addr_o,
    input  logic                            cache_hit_i,
    input  logic [DW-1:0]                   cache_data_i,
    output logic                            resp_valid_o,
    output logic [DW-1:0]                   resp_data_o,
    output logic                            mem_req_valid_o,
    output logic [AW-1:0]                   mem_req_addr_o,
    input  logic                            mem_req_ready_i,
    input  logic                            mem_rsp_valid_i,
    input  logic [DW-1:0]                   mem_rsp_data_i,
    output logic                            fill_inval_o,
    output logic                            fill_we_o,
    output logic                            fill_line_we_o,
    output logic [INDEX_W-1:0]              fill_index_o,
    output logic [OFFSET_W-1:0]             fill_word_o,
    output logic [AW-INDEX_W-OFFSET_W-1:0]  fill_tag_o,
    output logic [DW-1:0]                   fill_data_o,
    output logic                            busy_o
);

    localparam int TAG_W = AW - INDEX_W - OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = '1;

    state_e              state_q, state_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [OFFSET_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]       resp_data_q, resp_data_d;
    logic                hit_rsp_q, hit_rsp_d;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;

    assign {tag, index, offset} = addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            beat_cnt_q  <= '0;
            resp_data_q <= '0;
            hit_rsp_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            beat_cnt_q  <= beat_cnt_d;
            resp_data_q <= resp_data_d;
            hit_rsp_q   <= hit_rsp_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        beat_cnt_d      = beat_cnt_q;
        resp_data_d     = resp_data_q;
        hit_rsp_d       = 1'b0;
        req_ready_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        fill_inval_o    = 1'b0;
        fill_we_o       = 1'b0;
        fill_line_we_o  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (cache_hit_i) begin
                    resp_data_d = cache_data_i;
                    hit_rsp_d   = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    // Invalidate up front so an interrupted refill never leaves a stale-valid line.
                    fill_inval_o = 1'b1;
                    state_d      = ST_MREQ;
                end
            end
            ST_MREQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    beat_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_rsp_valid_i) begin
                    fill_we_o = 1'b1;
                    if (beat_cnt_q == offset) begin
                        resp_data_d = mem_rsp_data_i;
                    end
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        fill_line_we_o = 1'b1;
                        state_d        = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lookup_addr_o  = addr_q;
    assign mem_req_addr_o = {tag, index, {OFFSET_W{1'b0}}};
    assign fill_index_o   = index;
    assign fill_tag_o     = tag;
    assign fill_word_o    = beat_cnt_q;
    assign fill_data_o    = mem_rsp_data_i;
    assign resp_data_o    = resp_data_q;
    // Hits respond from IDLE via the registered pulse; refills respond from RESP.
    assign resp_valid_o   = hit_rsp_q || (state_q == ST_RESP);
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmcache_refill_ctrl.sv
// Directed bench for dmcache_refill_ctrl with a dmcache array model, a memory
// responder and a response scoreboard.
module tb_dmcache_refill_ctrl;
    import dmcache_defs_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req_valid, req_ready, cache_hit, resp_valid;
    logic [7:0] req_addr, lookup_addr, cache_data, resp_data;
    logic       mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [7:0] mem_req_addr, mem_rsp_data, fill_data;
    logic       fill_inval, fill_we, fill_line_we, busy;
    logic [1:0] fill_index, fill_word;
    logic [3:0] fill_tag;

    always #5 clk = ~clk;

    dmcache_refill_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
        .lookup_addr_o(lookup_addr), .cache_hit_i(cache_hit), .cache_data_i(cache_data),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .mem_req_valid_o(mem_req_valid), .mem_req_addr_o(mem_req_addr),
        .mem_req_ready_i(mem_req_ready), .mem_rsp_valid_i(mem_rsp_valid),
        .mem_rsp_data_i(mem_rsp_data),
        .fill_inval_o(fill_inval), .fill_we_o(fill_we), .fill_line_we_o(fill_line_we),
        .fill_index_o(fill_index), .fill_word_o(fill_word), .fill_tag_o(fill_tag),
        .fill_data_o(fill_data), .busy_o(busy)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    bit model_clr = 1'b1;
    logic [7:0] sb[$];
    logic [7:0] gmem[256];

    int acc_cnt = 0, acc_cyc = 0, resp_cnt = 0, resp_cyc = 0;
    int inval_cnt = 0, we_cnt = 0, we_seq = 0, line_cnt = 0;
    int mreq_cnt = 0, mreqv_cnt = 0, hold_n = 0;
    logic [1:0] inval_idx = '0, line_idx = '0;
    logic [3:0] line_tag = '0;
    logic [7:0] mreq_addr = '0, mreq_prev = '0, last_resp = '0;
    bit mreq_wait = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // dmcache array model, written only through the fill_* interface
    logic       mv[4];
    logic [3:0] mt[4];
    logic [7:0] md[4][4];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (model_clr) begin
            for (int i = 0; i < 4; i++) mv[i] <= 1'b0;
        end else begin
            if (fill_inval) mv[fill_index] <= 1'b0;
            if (fill_we) md[fill_index][fill_word] <= fill_data;
            if (fill_line_we) begin
                mv[fill_index] <= 1'b1;
                mt[fill_index] <= fill_tag;
            end
        end
    end

    always_comb begin
        cache_hit  = mv[lookup_addr[3:2]] && (mt[lookup_addr[3:2]] == lookup_addr[7:4]);
        cache_data = md[lookup_addr[3:2]][lookup_addr[1:0]];
    end

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (req_valid && req_ready) begin
                acc_cnt++;
                acc_cyc = cyc;
            end
            if (busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
            if (fill_inval) begin
                inval_cnt++;
                inval_idx = fill_index;
            end
            if (fill_we) begin
                chk("fill_word", 32'(fill_word), 32'(we_seq));
                chk("fill_data", 32'(fill_data), 32'(mem_rsp_data));
                we_seq++;
                we_cnt++;
            end
            if (fill_line_we) begin
                line_cnt++;
                line_tag = fill_tag;
                line_idx = fill_index;
            end
            if (mem_req_valid) mreqv_cnt++;
            if (mreq_wait) begin
                hold_n++;
                chk("mreq_hold_valid", 32'(mem_req_valid), 32'd1);
                chk("mreq_hold_addr", 32'(mem_req_addr), 32'(mreq_prev));
            end
            mreq_wait = mem_req_valid && !mem_req_ready;
            mreq_prev = mem_req_addr;
            if (mem_req_valid && mem_req_ready) begin
                mreq_cnt++;
                mreq_addr = mem_req_addr;
                we_seq = 0;
            end
            if (resp_valid) begin
                resp_cnt++;
                resp_cyc = cyc;
                last_resp = resp_data;
                chk("resp_unexpected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("resp_data", 32'(resp_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic issue(input logic [7:0] a);
        int n = 0;
        req_addr  = a;
        req_valid = 1'b1;
        sb.push_back(gmem[a]);
        while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("req_timeout", 32'(n >= 100), 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic mem_serve(input int dly, input int nbeats);
        int n = 0;
        logic [7:0] line;
        while (!mem_req_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("mreq_timeout", 32'(n >= 50), 32'd0);
        if (n < 50) begin
            repeat (dly) begin @(posedge clk); #1; end
            line = mem_req_addr;
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            for (int b = 0; b < nbeats; b++) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = gmem[line + 8'(b)];
                @(posedge clk); #1;
            end
            mem_rsp_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin @(posedge clk); #1; n++; end
        chk("idle_timeout", 32'(n >= 200), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int p_inv, p_we, p_line, p_mreq, p_mreqv, p_resp, p_acc, p_hold;
        for (int i = 0; i < 256; i++) gmem[i] = 8'(i * 7 + 3);
        gmem[8'h04] = 8'hA0; gmem[8'h05] = 8'hA1; gmem[8'h06] = 8'hA2; gmem[8'h07] = 8'hA3;
        req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        // 1: asynchronous reset asserted mid-cycle takes effect without a clock edge
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_fill_we", 32'(fill_we | fill_inval | fill_line_we), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        @(posedge clk); #1;
        model_clr = 1'b0;
        rst_n = 1'b1;
        mon_en = 1'b1;

        // 2: cold miss on 0x06
        p_inv = inval_cnt; p_we = we_cnt; p_line = line_cnt; p_mreq = mreq_cnt;
        issue(8'h06);
        mem_serve(3, 4);
        wait_idle();
        chk("t2_inval_n", 32'(inval_cnt - p_inv), 32'd1);
        chk("t2_inval_idx", 32'(inval_idx), 32'd1);
        chk("t2_mreq_n", 32'(mreq_cnt - p_mreq), 32'd1);
        chk("t2_mreq_addr", 32'(mreq_addr), 32'h04);
        chk("t2_fill_we_n", 32'(we_cnt - p_we), 32'd4);
        chk("t2_line_n", 32'(line_cnt - p_line), 32'd1);
        chk("t2_line_tag", 32'(line_tag), 32'd0);
        chk("t2_line_idx", 32'(line_idx), 32'd1);
        chk("t2_resp", 32'(last_resp), 32'hA2);

        // 3: hit on the freshly filled line
        p_mreqv = mreqv_cnt; p_resp = resp_cnt;
        issue(8'h05);
        wait_idle();
        chk("t3_resp_n", 32'(resp_cnt - p_resp), 32'd1);
        chk("t3_latency", 32'(resp_cyc - acc_cyc), 32'd2);
        chk("t3_resp", 32'(last_resp), 32'hA1);
        chk("t3_no_mreq", 32'(mreqv_cnt - p_mreqv), 32'd0);

        // 4: memory stalls while the requester keeps req_valid high
        p_acc = acc_cnt; p_hold = hold_n;
        sb.push_back(gmem[8'h2B]);
        sb.push_back(gmem[8'h2B]);
        req_addr = 8'h2B;
        req_valid = 1'b1;
        mem_serve(5, 4);
        chk("t4_one_accept", 32'(acc_cnt - p_acc), 32'd1);
        chk("t4_resp_state_ready", 32'(req_ready), 32'd0);
        chk("t4_hold_cycles", 32'(hold_n - p_hold), 32'd5);
        @(posedge clk); #1;
        chk("t4_ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t4_second_accept", 32'(acc_cnt - p_acc), 32'd2);
        wait_idle();

        // 5: reset in the middle of a refill of index 2
        p_line = line_cnt; p_we = we_cnt;
        issue(8'h59);
        mem_serve(0, 2);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_ready", 32'(req_ready), 32'd1);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("t5_no_line_we", 32'(line_cnt - p_line), 32'd0);
        chk("t5_partial_we", 32'(we_cnt - p_we), 32'd2);
        chk("t5_line_invalid", 32'(mv[2]), 32'd0);
        p_line = line_cnt; p_we = we_cnt;
        issue(8'h59);
        mem_serve(0, 4);
        wait_idle();
        chk("t5_refetch_we", 32'(we_cnt - p_we), 32'd4);
        chk("t5_refetch_line", 32'(line_cnt - p_line), 32'd1);
        chk("t5_resp", 32'(last_resp), 32'(gmem[8'h59]));

        // stray memory handshakes while idle are ignored
        p_we = we_cnt; p_mreq = mreq_cnt;
        mem_rsp_valid = 1'b1; mem_req_ready = 1'b1; mem_rsp_data = 8'h77;
        repeat (3) begin @(posedge clk); #1; end
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
        chk("idle_rsp_ignored", 32'(we_cnt - p_we), 32'd0);
        chk("idle_ready_ignored", 32'(mreq_cnt - p_mreq), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // 6: conflict on index 1
        p_mreq = mreq_cnt;
        issue(8'h06);
        wait_idle();
        chk("t6_first_hit", 32'(mreq_cnt - p_mreq), 32'd0);
        p_inv = inval_cnt;
        issue(8'h46);
        mem_serve(0, 4);
        wait_idle();
        chk("t6_inval_n", 32'(inval_cnt - p_inv), 32'd1);
        chk("t6_inval_idx", 32'(inval_idx), 32'd1);
        chk("t6_mreq_addr", 32'(mreq_addr), 32'h44);
        chk("t6_line_tag", 32'(line_tag), 32'd4);
        chk("t6_resp", 32'(last_resp), 32'(gmem[8'h46]));
        p_mreq = mreq_cnt;
        issue(8'h06);
        mem_serve(0, 4);
        wait_idle();
        chk("t6_remiss", 32'(mreq_cnt - p_mreq), 32'd1);
        chk("t6_remiss_addr", 32'(mreq_addr), 32'h04);
        chk("t6_remiss_resp", 32'(last_resp), 32'hA2);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
